// File: rtl/csr_hpm_counters.sv
// csr_hpm_counters: machine counter bank with mcycle, minstret, COUNTER_COUNT
// mhpmcounters, their mhpmevent selectors, mcountinhibit, and read-only user
// mirrors at C00/C80.
// Optional feature macro: CSR_HPM_OVERFLOW_EN adds sticky overflow flags in
// mhpmevent bit 31 and a registered overflowInterrupt. Without the macro,
// bit 31 reads 0 and overflowInterrupt is tied low.
module csr_hpm_counters #(
    parameter int unsigned COUNTER_COUNT = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned EVENT_COUNT   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   csrWriteEnable,
    input  logic                   csrReadEnable,
    input  logic [11:0]            csrWriteAddress,
    input  logic [11:0]            csrReadAddress,
    input  logic [31:0]            csrWriteData,
    output logic [31:0]            csrReadData,
    output logic                   csrRequestOutput,
    input  logic                   instructionCompleted,
    input  logic [EVENT_COUNT-1:0] events,
    output logic                   overflowInterrupt
);

    // Slot 0 = mcycle, slot 1 = unused (time lives elsewhere), slot 2 = minstret,
    // slots 3..COUNTER_COUNT+2 = mhpmcounters.
    localparam int unsigned SLOTS    = COUNTER_COUNT + 3;
    localparam int unsigned HI_W     = COUNTER_WIDTH - 32;
    localparam logic [4:0]  LAST_IDX = 5'(COUNTER_COUNT + 2);
    localparam logic [6:0]  EVT_PAGE = 7'h19;   // 0x320..0x33F

    function automatic logic [31:0] inhibit_mask();
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int unsigned i = 3; i < SLOTS; i++) begin
            m = m | (32'd1 << i);
        end
        return m;
    endfunction

    localparam logic [31:0] INH_MASK = inhibit_mask();

    function automatic logic ctr_idx_ok(input logic [4:0] idx);
        return (idx == 5'd0) || ((idx >= 5'd2) && (idx <= LAST_IDX));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [COUNTER_WIDTH-1:0] cnt_q [SLOTS];
    logic [COUNTER_WIDTH-1:0] cnt_d [SLOTS];
    logic [7:0]               sel_q [COUNTER_COUNT];
    logic [7:0]               sel_d [COUNTER_COUNT];
    logic [31:0]              inh_q;
    logic [31:0]              inh_d;

    logic [SLOTS-1:0]         inc;
    logic [COUNTER_COUNT-1:0] of_bits;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic [4:0] w_idx;
    logic [4:0] r_idx;
    logic       wr_cnt;
    logic       wr_hi;
    logic       wr_evt;
    logic       wr_inh;

    assign w_idx  = csrWriteAddress[4:0];
    assign r_idx  = csrReadAddress[4:0];
    assign wr_cnt = csrWriteEnable && (csrWriteAddress[11:8] == 4'hB)
                    && (csrWriteAddress[6:5] == 2'b00) && ctr_idx_ok(w_idx);
    assign wr_hi  = csrWriteAddress[7];
    assign wr_evt = csrWriteEnable && (csrWriteAddress[11:5] == EVT_PAGE)
                    && (w_idx >= 5'd3) && (w_idx <= LAST_IDX);
    assign wr_inh = csrWriteEnable && (csrWriteAddress == 12'h320);

    // Per-counter increment requests after applying selectors and inhibits.
    always_comb begin
        inc    = '0;
        inc[0] = ~inh_q[0];
        inc[2] = instructionCompleted & ~inh_q[2];
        for (int unsigned i = 0; i < COUNTER_COUNT; i++) begin
            for (int unsigned e = 0; e < EVENT_COUNT; e++) begin
                if ((sel_q[i] == 8'(e + 1)) && events[e] && !inh_q[i + 3]) begin
                    inc[i + 3] = 1'b1;
                end
            end
        end
    end

    // Counter next-state: a low-half write replaces the low word and loses the
    // increment; a high-half write keeps the incremented low word but drops its carry.
    logic [COUNTER_WIDTH-1:0] sum;
    logic                     wr_this;
    always_comb begin
        sum     = '0;
        wr_this = 1'b0;
        for (int unsigned n = 0; n < SLOTS; n++) begin
            sum      = cnt_q[n] + COUNTER_WIDTH'(inc[n]);
            wr_this  = wr_cnt && (w_idx == 5'(n));
            cnt_d[n] = sum;
            if (wr_this && wr_hi) begin
                cnt_d[n] = {csrWriteData[HI_W-1:0], sum[31:0]};
            end else if (wr_this) begin
                cnt_d[n] = {cnt_q[n][COUNTER_WIDTH-1:32], csrWriteData};
            end
            if (n == 1) begin
                cnt_d[n] = '0;
            end
        end
    end

    // Selector and inhibit next-state from CSR writes.
    always_comb begin
        sel_d = sel_q;
        inh_d = inh_q;
        for (int unsigned i = 0; i < COUNTER_COUNT; i++) begin
            if (wr_evt && (w_idx == 5'(i + 3))) begin
                sel_d[i] = csrWriteData[7:0];
            end
        end
        if (wr_inh) begin
            inh_d = csrWriteData & INH_MASK;
        end
    end

    // Counter, selector and inhibit registers; reset overrides a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '{default: '0};
            sel_q <= '{default: '0};
            inh_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            inh_q <= inh_d;
        end
    end

    // ------------------------------------------------------------------
    // Overflow tracking
    // ------------------------------------------------------------------
`ifdef CSR_HPM_OVERFLOW_EN
    logic [COUNTER_COUNT-1:0] of_q;
    logic [COUNTER_COUNT-1:0] of_d;
    logic [COUNTER_COUNT-1:0] wrap;
    logic                     irq_q;

    // OF sets on an increment wrap (not on writes); writing 0 to bit 31 clears it, set wins.
    always_comb begin
        wrap = '0;
        of_d = of_q;
        for (int unsigned i = 0; i < COUNTER_COUNT; i++) begin
            wrap[i] = inc[i + 3] && (&cnt_q[i + 3])
                      && !(wr_cnt && (w_idx == 5'(i + 3)));
            if (wr_evt && (w_idx == 5'(i + 3)) && !csrWriteData[31]) begin
                of_d[i] = 1'b0;
            end
            if (wrap[i]) begin
                of_d[i] = 1'b1;
            end
        end
    end

    // Sticky flags and the interrupt, which follows the flags one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            of_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            of_q  <= of_d;
            irq_q <= |of_q;
        end
    end

    assign of_bits           = of_q;
    assign overflowInterrupt = irq_q;
`else
    assign of_bits           = '0;
    assign overflowInterrupt = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [63:0] rd_wide;

    // Combinational read mux; counter values are zero-extended to 64 bits.
    always_comb begin
        csrReadData      = '0;
        csrRequestOutput = 1'b0;
        rd_wide          = '0;
        for (int unsigned n = 0; n < SLOTS; n++) begin
            if (r_idx == 5'(n)) begin
                rd_wide = 64'(cnt_q[n]);
            end
        end
        if (csrReadEnable) begin
            if (((csrReadAddress[11:8] == 4'hB) || (csrReadAddress[11:8] == 4'hC))
                && (csrReadAddress[6:5] == 2'b00) && ctr_idx_ok(r_idx)) begin
                csrRequestOutput = 1'b1;
                csrReadData      = csrReadAddress[7] ? rd_wide[63:32] : rd_wide[31:0];
            end else if (csrReadAddress == 12'h320) begin
                csrRequestOutput = 1'b1;
                csrReadData      = inh_q;
            end else if ((csrReadAddress[11:5] == EVT_PAGE)
                         && (r_idx >= 5'd3) && (r_idx <= LAST_IDX)) begin
                csrRequestOutput = 1'b1;
                for (int unsigned i = 0; i < COUNTER_COUNT; i++) begin
                    if (r_idx == 5'(i + 3)) begin
                        csrReadData = {of_bits[i], 23'd0, sel_q[i]};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Bench for csr_hpm_counters: two instances (64-bit and 40-bit counters)
// share stimulus and are compared against an arithmetic reference model.
module tb_csr_hpm_counters;

    localparam int unsigned CC = 4;
    localparam int unsigned EC = 8;
`ifdef CSR_HPM_OVERFLOW_EN
    localparam bit OF_EN = 1'b1;
`else
    localparam bit OF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          rst = 1'b1;
    logic          we  = 1'b0;
    logic          re  = 1'b0;
    logic          ic  = 1'b0;
    logic [11:0]   wa  = '0;
    logic [11:0]   ra  = '0;
    logic [31:0]   wd  = '0;
    logic [EC-1:0] ev  = '0;
    logic [31:0]   rd64, rd40;
    logic          req64, req40, irq64, irq40;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    csr_hpm_counters #(.COUNTER_COUNT(CC), .COUNTER_WIDTH(64), .EVENT_COUNT(EC)) dut64 (
        .clk(clk), .rst(rst),
        .csrWriteEnable(we), .csrReadEnable(re),
        .csrWriteAddress(wa), .csrReadAddress(ra),
        .csrWriteData(wd), .csrReadData(rd64), .csrRequestOutput(req64),
        .instructionCompleted(ic), .events(ev), .overflowInterrupt(irq64)
    );

    csr_hpm_counters #(.COUNTER_COUNT(CC), .COUNTER_WIDTH(40), .EVENT_COUNT(EC)) dut40 (
        .clk(clk), .rst(rst),
        .csrWriteEnable(we), .csrReadEnable(re),
        .csrWriteAddress(wa), .csrReadAddress(ra),
        .csrWriteData(wd), .csrReadData(rd40), .csrRequestOutput(req40),
        .instructionCompleted(ic), .events(ev), .overflowInterrupt(irq40)
    );

    // Reference model: index 0 = 64-bit instance, index 1 = 40-bit instance.
    longint unsigned m_cnt [2][CC+3];
    logic [7:0]      m_sel [2][CC];
    logic [31:0]     m_inh [2];
    bit              m_of  [2][CC];
    bit              m_irq [2];

    function automatic longint unsigned width_mask(input int k);
        return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << 40) - 64'd1);
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            longint unsigned msk;
            msk = width_mask(k);
            if (rst) begin
                for (int n = 0; n < CC + 3; n++) m_cnt[k][n] = 0;
                for (int i = 0; i < CC; i++) begin
                    m_sel[k][i] = '0;
                    m_of[k][i]  = 1'b0;
                end
                m_inh[k] = '0;
                m_irq[k] = 1'b0;
            end else begin
                m_irq[k] = 1'b0;
                for (int i = 0; i < CC; i++) if (m_of[k][i]) m_irq[k] = 1'b1;
                for (int n = 0; n < CC + 3; n++) begin
                    bit              inc, wrote, wrap_now, clr;
                    longint unsigned sum, old;
                    int unsigned     s;
                    inc   = 1'b0;
                    wrote = 1'b0;
                    old   = m_cnt[k][n];
                    if (n == 0) inc = !m_inh[k][0];
                    else if (n == 2) inc = ic && !m_inh[k][2];
                    else if (n >= 3) begin
                        s   = int'(m_sel[k][n-3]);
                        inc = (s >= 1) && (s <= EC) && ev[s-1] && !m_inh[k][n];
                    end
                    sum = (old + 64'(inc)) & msk;
                    if (we && n != 1 && wa == 12'hB00 + 12'(n)) begin
                        m_cnt[k][n] = (old & 64'hFFFF_FFFF_0000_0000) | 64'(wd);
                        wrote = 1'b1;
                    end else if (we && n != 1 && wa == 12'hB80 + 12'(n)) begin
                        m_cnt[k][n] = ((64'(wd) << 32) | (sum & 64'hFFFF_FFFF)) & msk;
                        wrote = 1'b1;
                    end else begin
                        m_cnt[k][n] = sum;
                    end
                    if (n >= 3) begin
                        wrap_now = inc && (old == msk) && !wrote;
                        clr      = we && (wa == 12'h320 + 12'(n)) && !wd[31];
                        if (OF_EN) m_of[k][n-3] = wrap_now || (m_of[k][n-3] && !clr);
                    end
                end
                for (int i = 0; i < CC; i++)
                    if (we && wa == 12'h323 + 12'(i)) m_sel[k][i] = wd[7:0];
                if (we && wa == 12'h320)
                    m_inh[k] = wd & (32'h5 | (((32'd1 << CC) - 32'd1) << 3));
            end
        end
    endtask

    function automatic void model_read(input int k, input logic [11:0] a,
                                       output bit hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (a == 12'h320) begin
            hit  = 1'b1;
            data = m_inh[k];
        end
        for (int i = 0; i < CC; i++) begin
            if (a == 12'h323 + 12'(i)) begin
                hit  = 1'b1;
                data = {m_of[k][i], 23'd0, m_sel[k][i]};
            end
        end
        for (int n = 0; n < CC + 3; n++) begin
            if (n == 1) continue;
            if (a == 12'hB00 + 12'(n) || a == 12'hC00 + 12'(n)) begin
                hit  = 1'b1;
                data = m_cnt[k][n][31:0];
            end
            if (a == 12'hB80 + 12'(n) || a == 12'hC80 + 12'(n)) begin
                hit  = 1'b1;
                data = m_cnt[k][n][63:32];
            end
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] a);
        re = 1'b1;
        ra = a;
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        we = 1'b1;
        wa = a;
        wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] hits [4];
        hits = '{12'hB00, 12'hB83, 12'h323, 12'h320};
        rst = 1'b1; we = 1'b1; wa = 12'hB00; wd = 32'h1234_5678; ev = '1; ic = 1'b1;
        tick();
        tick();
        rst = 1'b0; we = 1'b0; ev = '0; ic = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(hits[i]);
            n_checks++;
            if (rd64 !== 32'd0 || rd40 !== 32'd0 || req64 !== 1'b1 || req40 !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_read %h: got %h/%h req %b%b, want 00000000 req 11",
                         hits[i], rd64, rd40, req64, req40);
            end
        end
        rd(12'hB80 + 12'(CC + 3));
        n_checks++;
        if (rd64 !== 32'd0 || rd40 !== 32'd0 || req64 !== 1'b0 || req40 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nomatch: got %h/%h req %b%b, want 00000000 req 00",
                     rd64, rd40, req64, req40);
        end
        n_checks++;
        if (irq64 !== 1'b0 || irq40 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b%b, want 00", irq64, irq40);
        end
    endtask

    task automatic test_carry();
        logic [11:0] as [4];
        as = '{12'hB00, 12'hB80, 12'hC00, 12'hC80};
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            rd(as[i]);
            n_checks++;
            if (rd64 !== 32'h1 || rd40 !== 32'h1 || req64 !== 1'b1) begin
                n_fail++;
                $display("FAIL carry %h: got %h/%h, want 00000001", as[i], rd64, rd40);
            end
        end
    endtask

    task automatic test_event_count();
        wr(12'h323, 32'h3);
        for (int c = 0; c < 9; c++) begin
            ev = '0;
            if (c % 2 == 0) ev[2] = 1'b1;
            else ev[0] = 1'b1;
            tick();
            ev = '0;
            tick();
        end
        rd(12'hB03);
        n_checks++;
        if (rd64 !== 32'd5 || rd40 !== 32'd5) begin
            n_fail++;
            $display("FAIL event_count: got %h/%h, want 00000005", rd64, rd40);
        end
        rd(12'h323);
        n_checks++;
        if (rd64 !== 32'h3 || rd40 !== 32'h3) begin
            n_fail++;
            $display("FAIL event_sel: got %h/%h, want 00000003", rd64, rd40);
        end
        wr(12'h320, 32'h8);
        for (int c = 0; c < 3; c++) begin
            ev[2] = 1'b1;
            tick();
            ev = '0;
            tick();
        end
        rd(12'hB03);
        n_checks++;
        if (rd64 !== 32'd5 || rd40 !== 32'd5) begin
            n_fail++;
            $display("FAIL event_inhibit: got %h/%h, want 00000005", rd64, rd40);
        end
        wr(12'h320, 32'hFFFF_FFFF);
        rd(12'h320);
        n_checks++;
        if (rd64 !== 32'h0000_007D || rd40 !== 32'h0000_007D) begin
            n_fail++;
            $display("FAIL inhibit_mask: got %h/%h, want 0000007d", rd64, rd40);
        end
        tick();
        tick();
        rd(12'hB00);
        n_checks++;
        if (rd64 !== m_cnt[0][0][31:0] || rd40 !== m_cnt[1][0][31:0]) begin
            n_fail++;
            $display("FAIL mcycle_frozen: got %h/%h, want %h/%h",
                     rd64, rd40, m_cnt[0][0][31:0], m_cnt[1][0][31:0]);
        end
        wr(12'h320, 32'h0);
    endtask

    task automatic test_instret();
        ic = 1'b1;
        wr(12'hB02, 32'h10);
        rd(12'hB02);
        n_checks++;
        if (rd64 !== 32'h10 || rd40 !== 32'h10) begin
            n_fail++;
            $display("FAIL instret_write: got %h/%h, want 00000010", rd64, rd40);
        end
        tick();
        rd(12'hB02);
        n_checks++;
        if (rd64 !== 32'h11 || rd40 !== 32'h11) begin
            n_fail++;
            $display("FAIL instret_inc: got %h/%h, want 00000011", rd64, rd40);
        end
        wr(12'hC02, 32'h0);
        rd(12'hC02);
        n_checks++;
        if (rd64 !== 32'h12 || rd40 !== 32'h12 || req64 !== 1'b1 || req40 !== 1'b1) begin
            n_fail++;
            $display("FAIL user_write_ignored: got %h/%h req %b%b, want 00000012 req 11",
                     rd64, rd40, req64, req40);
        end
        ic = 1'b0;
    endtask

    task automatic test_width_and_overflow();
        logic [31:0] of_word;
        of_word = OF_EN ? 32'h8000_0003 : 32'h0000_0003;
        wr(12'hB83, 32'hFFFF_FFFF);
        rd(12'hB83);
        n_checks++;
        if (rd64 !== 32'hFFFF_FFFF || rd40 !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL width_hi: got %h/%h, want ffffffff/000000ff", rd64, rd40);
        end
        wr(12'hB03, 32'hFFFF_FFFF);
        ev[2] = 1'b1;
        tick();
        ev = '0;
        rd(12'hB03);
        n_checks++;
        if (rd64 !== 32'h0 || rd40 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_lo: got %h/%h, want 00000000", rd64, rd40);
        end
        rd(12'hB83);
        n_checks++;
        if (rd64 !== 32'h0 || rd40 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_hi: got %h/%h, want 00000000", rd64, rd40);
        end
        rd(12'h323);
        n_checks++;
        if (rd64 !== of_word || rd40 !== of_word) begin
            n_fail++;
            $display("FAIL of_flag: got %h/%h, want %h", rd64, rd40, of_word);
        end
        n_checks++;
        if (irq64 !== 1'b0 || irq40 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_latency: got %b%b, want 00", irq64, irq40);
        end
        tick();
        n_checks++;
        if (irq64 !== OF_EN || irq40 !== OF_EN) begin
            n_fail++;
            $display("FAIL irq_rise: got %b%b, want %b%b", irq64, irq40, OF_EN, OF_EN);
        end
        wr(12'h323, 32'h3);
        tick();
        n_checks++;
        if (irq64 !== 1'b0 || irq40 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: got %b%b, want 00", irq64, irq40);
        end
        wr(12'h323, 32'h8000_0003);
        rd(12'h323);
        n_checks++;
        if (rd64 !== 32'h3 || rd40 !== 32'h3) begin
            n_fail++;
            $display("FAIL of_no_write_set: got %h/%h, want 00000003", rd64, rd40);
        end
        wr(12'hB83, 32'hFFFF_FFFF);
        wr(12'hB03, 32'hFFFF_FFFF);
        we = 1'b1; wa = 12'h323; wd = 32'h3; ev[2] = 1'b1;
        tick();
        we = 1'b0; ev = '0;
        rd(12'h323);
        n_checks++;
        if (rd64 !== of_word || rd40 !== of_word) begin
            n_fail++;
            $display("FAIL of_set_wins: got %h/%h, want %h", rd64, rd40, of_word);
        end
        wr(12'h323, 32'h3);
        tick();
    endtask

    task automatic test_random();
        logic [11:0] addrs [$];
        addrs = '{12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB07,
                  12'hB80, 12'hB81, 12'hB82, 12'hB83, 12'hB86, 12'hB87,
                  12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC06, 12'hC07,
                  12'hC80, 12'hC82, 12'hC86, 12'h320, 12'h321, 12'h322,
                  12'h323, 12'h324, 12'h325, 12'h326, 12'h327, 12'h300};
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 3) == 0);
            wa  = addrs[$urandom_range(0, addrs.size() - 1)];
            case ($urandom_range(0, 3))
                0:       wd = 32'hFFFF_FFFF;
                1:       wd = $urandom_range(0, 15);
                default: wd = $urandom;
            endcase
            if (wa == 12'h320 && $urandom_range(0, 1) == 1) wd = 32'h0;
            ev = EC'($urandom);
            ic = $urandom_range(0, 1);
            rd(addrs[$urandom_range(0, addrs.size() - 1)]);
            for (int k = 0; k < 2; k++) begin
                bit          eh;
                logic [31:0] ed;
                logic [31:0] ad;
                logic        ah;
                model_read(k, ra, eh, ed);
                ad = (k == 0) ? rd64 : rd40;
                ah = (k == 0) ? req64 : req40;
                n_checks++;
                if (ah !== eh || ad !== ed) begin
                    n_fail++;
                    $display("FAIL random_read w%0d addr %h cycle %0d: got %h req %b, want %h req %b",
                             (k == 0) ? 64 : 40, ra, c, ad, ah, ed, eh);
                end
            end
            n_checks++;
            if (irq64 !== m_irq[0] || irq40 !== m_irq[1]) begin
                n_fail++;
                $display("FAIL random_irq cycle %0d: got %b%b, want %b%b",
                         c, irq64, irq40, m_irq[0], m_irq[1]);
            end
            tick();
        end
        rst = 1'b0; we = 1'b0; ev = '0; ic = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_carry();
        test_event_count();
        test_instret();
        test_width_and_overflow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
